// File: rtl/decode_pkg.sv
// Shared types and instruction field positions for the decode stage.
package decode_pkg;

    typedef enum logic [3:0] {
        OP_CMP   = 4'd0,
        OP_J     = 4'd1,
        OP_VXOR  = 4'd2,
        OP_VXORI = 4'd3,
        OP_VLD   = 4'd4,
        OP_VSTR  = 4'd5,
        OP_VSR   = 4'd6,
        OP_VSL   = 4'd7,
        OP_VSWAP = 4'd8,
        OP_ADD   = 4'd9,
        OP_SUB   = 4'd10,
        OP_ADDI  = 4'd11,
        OP_SUBI  = 4'd12,
        OP_NOP   = 4'd13,
        OP_END   = 4'd14,
        OP_ILL   = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        COND_EQ = 2'd0,
        COND_GT = 2'd1,
        COND_AL = 2'd2,
        COND_NE = 2'd3
    } cond_e;

    typedef enum logic [2:0] {
        ALU_XOR = 3'd0,
        ALU_SR  = 3'd1,
        ALU_SL  = 3'd2,
        ALU_ADD = 3'd3,
        ALU_SUB = 3'd4,
        ALU_CMP = 3'd5
    } alu_op_e;

    // Native field widths carried by the instruction word. The top widens
    // these to its parameterised output widths by zero-extension.
    localparam int INT_REG_BW = 4;
    localparam int VREG_BW    = 2;
    localparam int IMM_BW     = 5;
    localparam int ADDR_BW    = 10;
    localparam int SWAP_BW    = 3;

    // Field LSB positions within the 16-bit instruction.
    localparam int COND_LSB      = 14;
    localparam int CMP_SRC1_LSB  = 10;
    localparam int CMP_SRC2_LSB  = 6;
    localparam int JMP_ADDR_LSB  = 4;
    localparam int VA_SRC_LSB    = 11;
    localparam int VA_DST_LSB    = 9;
    localparam int VA_INT_LSB    = 5;
    localparam int VA_IMM_LSB    = 4;
    localparam int MEM_BASE_LSB  = 10;
    localparam int MEM_VREG_LSB  = 8;
    localparam int MEM_IMM_LSB   = 5;
    localparam int SWP_SRC_LSB   = 12;
    localparam int SWP_DST_LSB   = 10;
    localparam int SWP_ORG_LSB   = 7;
    localparam int SWP_BDST_LSB  = 4;
    localparam int INT_SRC1_LSB  = 12;
    localparam int INT_DST_LSB   = 8;
    localparam int INT_SRC2_LSB  = 4;

    typedef struct packed {
        logic [INT_REG_BW-1:0] intOper1;
        logic [INT_REG_BW-1:0] intOper2;
        logic [INT_REG_BW-1:0] intRegDest;
        logic [VREG_BW-1:0]    vOper1;
        logic [VREG_BW-1:0]    vRegDest;
        cond_e                 cond;
        alu_op_e               aluOp;
        logic                  enableAluInt;
        logic                  enableAluV;
        logic                  enableMem;
        logic                  enableJump;
        logic                  enableSwap;
        logic                  flagImm;
        logic                  flagMemRead;
        logic                  flagMemWrite;
        logic                  flagNop;
        logic                  flagEnd;
        logic [IMM_BW-1:0]     imm;
        logic [ADDR_BW-1:0]    jumpAddress;
        logic [SWAP_BW-1:0]    swapBitOrigin;
        logic [SWAP_BW-1:0]    swapBitDest;
        logic                  illegal;
    } uop_t;

endpackage

// File: rtl/decode_stage_logic.sv
// Purely combinational instruction-to-micro-op decoder.
module decode_logic
    import decode_pkg::*;
(
    input  logic [15:0] instruction,
    output uop_t        uop
);

    // Start from an all-zero bundle so unused fields never carry stale data.
    always_comb begin
        uop = '0;
        case (opcode_e'(instruction[3:0]))
            OP_CMP: begin
                uop.intOper1     = instruction[CMP_SRC1_LSB +: 4];
                uop.intOper2     = instruction[CMP_SRC2_LSB +: 4];
                uop.cond         = COND_EQ;
                uop.aluOp        = ALU_CMP;
                uop.enableAluInt = 1'b1;
            end
            OP_J: begin
                uop.cond        = cond_e'(instruction[COND_LSB +: 2]);
                uop.jumpAddress = instruction[JMP_ADDR_LSB +: 10];
                uop.enableJump  = 1'b1;
            end
            OP_VXOR, OP_VSR, OP_VSL: begin
                uop.cond       = cond_e'(instruction[COND_LSB +: 2]);
                uop.vOper1     = instruction[VA_SRC_LSB +: 2];
                uop.vRegDest   = instruction[VA_DST_LSB +: 2];
                uop.intOper1   = instruction[VA_INT_LSB +: 4];
                uop.aluOp      = (instruction[3:0] == OP_VXOR) ? ALU_XOR :
                                 (instruction[3:0] == OP_VSR)  ? ALU_SR : ALU_SL;
                uop.enableAluV = 1'b1;
            end
            OP_VXORI: begin
                uop.cond       = cond_e'(instruction[COND_LSB +: 2]);
                uop.vOper1     = instruction[VA_SRC_LSB +: 2];
                uop.vRegDest   = instruction[VA_DST_LSB +: 2];
                uop.imm        = instruction[VA_IMM_LSB +: 5];
                uop.flagImm    = 1'b1;
                uop.aluOp      = ALU_XOR;
                uop.enableAluV = 1'b1;
            end
            OP_VLD, OP_VSTR: begin
                uop.cond     = cond_e'(instruction[COND_LSB +: 2]);
                uop.intOper1 = instruction[MEM_BASE_LSB +: 4];
                if (instruction[3:0] == OP_VLD) begin
                    uop.vRegDest    = instruction[MEM_VREG_LSB +: 2];
                    uop.flagMemRead = 1'b1;
                end else begin
                    uop.vOper1       = instruction[MEM_VREG_LSB +: 2];
                    uop.flagMemWrite = 1'b1;
                end
                uop.imm       = {2'b00, instruction[MEM_IMM_LSB +: 3]};
                uop.flagImm   = 1'b1;
                uop.enableMem = 1'b1;
            end
            OP_VSWAP: begin
                uop.cond          = cond_e'(instruction[COND_LSB +: 2]);
                uop.vOper1        = instruction[SWP_SRC_LSB +: 2];
                uop.vRegDest      = instruction[SWP_DST_LSB +: 2];
                uop.swapBitOrigin = instruction[SWP_ORG_LSB +: 3];
                uop.swapBitDest   = instruction[SWP_BDST_LSB +: 3];
                uop.enableSwap    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                uop.intOper1     = instruction[INT_SRC1_LSB +: 4];
                uop.intRegDest   = instruction[INT_DST_LSB +: 4];
                uop.intOper2     = instruction[INT_SRC2_LSB +: 4];
                uop.cond         = COND_AL;
                uop.aluOp        = (instruction[3:0] == OP_ADD) ? ALU_ADD : ALU_SUB;
                uop.enableAluInt = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                uop.intOper1     = instruction[INT_SRC1_LSB +: 4];
                uop.intRegDest   = instruction[INT_DST_LSB +: 4];
                uop.imm          = {1'b0, instruction[INT_SRC2_LSB +: 4]};
                uop.flagImm      = 1'b1;
                uop.cond         = COND_AL;
                uop.aluOp        = (instruction[3:0] == OP_ADDI) ? ALU_ADD : ALU_SUB;
                uop.enableAluInt = 1'b1;
            end
            OP_NOP: uop.flagNop = 1'b1;
            OP_END: uop.flagEnd = 1'b1;
            default: begin
                uop.illegal = 1'b1;
                uop.flagNop = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: handshake, flush, sticky halt, illegal counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | accepting instructions while the output slot allows
// ST_HALT | END accepted; no further accepts until reset
module decode_stage
    import decode_pkg::*;
#(
    parameter int INT_REG_W = 4,
    parameter int VREG_W    = 2,
    parameter int IMM_W     = 8,
    parameter int ADDR_W    = 10,
    parameter int SWAP_W    = 3,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          instruction,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INT_REG_W-1:0] intOper1,
    output logic [INT_REG_W-1:0] intOper2,
    output logic [INT_REG_W-1:0] intRegDest,
    output logic [VREG_W-1:0]    vOper1,
    output logic [VREG_W-1:0]    vRegDest,
    output logic [1:0]           cond,
    output logic [2:0]           aluOpcode,
    output logic                 enableAluInt,
    output logic                 enableAluV,
    output logic                 enableMem,
    output logic                 enableJump,
    output logic                 enableSwap,
    output logic                 flagImm,
    output logic                 flagMemRead,
    output logic                 flagMemWrite,
    output logic                 flagNop,
    output logic                 flagEnd,
    output logic [IMM_W-1:0]     ImmOut,
    output logic [ADDR_W-1:0]    jumpAddress,
    output logic [SWAP_W-1:0]    swapBitOrigin,
    output logic [SWAP_W-1:0]    swapBitDest,
    output logic                 illegal,
    output logic                 halted,
    output logic [ILL_CNT_W-1:0] illCount
);

    if (INT_REG_W < INT_REG_BW) begin : g_chkIntReg
        $error("INT_REG_W must be at least 4");
    end
    if (VREG_W < VREG_BW) begin : g_chkVreg
        $error("VREG_W must be at least 2");
    end
    if (IMM_W < IMM_BW) begin : g_chkImm
        $error("IMM_W must be at least 5");
    end
    if (ADDR_W < ADDR_BW) begin : g_chkAddr
        $error("ADDR_W must be at least 10");
    end
    if (SWAP_W < SWAP_BW) begin : g_chkSwap
        $error("SWAP_W must be at least 3");
    end
    if (ILL_CNT_W < 1) begin : g_chkIll
        $error("ILL_CNT_W must be at least 1");
    end

    typedef enum logic {ST_RUN, ST_HALT} run_state_e;

    run_state_e           state, stateNext;
    uop_t                 uopNext, uopQ;
    logic                 outValidQ;
    logic [ILL_CNT_W-1:0] illCountQ;
    logic                 accept;

    decode_logic u_decodeLogic (
        .instruction (instruction),
        .uop         (uopNext)
    );

    assign halted   = (state == ST_HALT);
    // out_ready reaches in_ready combinationally so a consumed slot refills in the same cycle.
    assign in_ready = !halted && (!outValidQ || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // Run/halt state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= stateNext;
    end

    // Halt is entered on the same edge that captures the END bundle.
    always_comb begin
        stateNext = state;
        case (state)
            ST_RUN:  if (accept && uopNext.flagEnd) stateNext = ST_HALT;
            ST_HALT: stateNext = ST_HALT;
            default: stateNext = ST_RUN;
        endcase
    end

    // Output slot, valid flag and saturating illegal counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValidQ <= 1'b0;
            uopQ      <= '0;
            illCountQ <= '0;
        end else if (flush) begin
            outValidQ <= 1'b0;
        end else if (accept) begin
            uopQ      <= uopNext;
            outValidQ <= 1'b1;
            if (uopNext.illegal && (illCountQ != '1))
                illCountQ <= illCountQ + ILL_CNT_W'(1);
        end else if (out_ready) begin
            outValidQ <= 1'b0;
        end
    end

    assign out_valid     = outValidQ;
    assign illCount      = illCountQ;
    assign intOper1      = INT_REG_W'(uopQ.intOper1);
    assign intOper2      = INT_REG_W'(uopQ.intOper2);
    assign intRegDest    = INT_REG_W'(uopQ.intRegDest);
    assign vOper1        = VREG_W'(uopQ.vOper1);
    assign vRegDest      = VREG_W'(uopQ.vRegDest);
    assign cond          = uopQ.cond;
    assign aluOpcode     = uopQ.aluOp;
    assign enableAluInt  = uopQ.enableAluInt;
    assign enableAluV    = uopQ.enableAluV;
    assign enableMem     = uopQ.enableMem;
    assign enableJump    = uopQ.enableJump;
    assign enableSwap    = uopQ.enableSwap;
    assign flagImm       = uopQ.flagImm;
    assign flagMemRead   = uopQ.flagMemRead;
    assign flagMemWrite  = uopQ.flagMemWrite;
    assign flagNop       = uopQ.flagNop;
    assign flagEnd       = uopQ.flagEnd;
    assign ImmOut        = IMM_W'(uopQ.imm);
    assign jumpAddress   = ADDR_W'(uopQ.jumpAddress);
    assign swapBitOrigin = SWAP_W'(uopQ.swapBitOrigin);
    assign swapBitDest   = SWAP_W'(uopQ.swapBitDest);
    assign illegal       = uopQ.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random traffic
// against a behavioural model of the handshake and instruction encodings.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] instruction = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  intOper1, intOper2, intRegDest;
    logic [1:0]  vOper1, vRegDest;
    logic [1:0]  cond;
    logic [2:0]  aluOpcode;
    logic        enableAluInt, enableAluV, enableMem, enableJump, enableSwap;
    logic        flagImm, flagMemRead, flagMemWrite, flagNop, flagEnd;
    logic [7:0]  ImmOut;
    logic [9:0]  jumpAddress;
    logic [2:0]  swapBitOrigin, swapBitDest;
    logic        illegal;
    logic        halted;
    logic [7:0]  illCount;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .intOper1(intOper1), .intOper2(intOper2),
        .intRegDest(intRegDest), .vOper1(vOper1), .vRegDest(vRegDest),
        .cond(cond), .aluOpcode(aluOpcode), .enableAluInt(enableAluInt),
        .enableAluV(enableAluV), .enableMem(enableMem), .enableJump(enableJump),
        .enableSwap(enableSwap), .flagImm(flagImm), .flagMemRead(flagMemRead),
        .flagMemWrite(flagMemWrite), .flagNop(flagNop), .flagEnd(flagEnd),
        .ImmOut(ImmOut), .jumpAddress(jumpAddress), .swapBitOrigin(swapBitOrigin),
        .swapBitDest(swapBitDest), .illegal(illegal), .halted(halted),
        .illCount(illCount)
    );

    always #5 clk = ~clk;

    logic [63:0] obsPack;
    assign obsPack = {8'd0, intOper1, intOper2, intRegDest, vOper1, vRegDest, cond,
                      aluOpcode, enableAluInt, enableAluV, enableMem, enableJump,
                      enableSwap, flagImm, flagMemRead, flagMemWrite, flagNop, flagEnd,
                      ImmOut, jumpAddress, swapBitOrigin, swapBitDest, illegal};

    int nChecks = 0;
    int nErrors = 0;

    // Model state
    bit          mValid = 0;
    bit          mHalted = 0;
    int          mIll = 0;
    logic [63:0] mBundle = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int fld(input int ins, input int lsb, input int w);
        return (ins >> lsb) & ((1 << w) - 1);
    endfunction

    // Expected bundle straight from the encoding table.
    function automatic logic [63:0] refDecode(input logic [15:0] insBits);
        int ins, op;
        int o1, o2, d, v1, vD, cnd, alu, eAI, eAV, eM, eJ, eS;
        int fImm, fMR, fMW, fNop, fEnd, imm, jmp, sO, sD, ill;
        ins = int'(insBits);
        op = ins & 15;
        o1 = 0; o2 = 0; d = 0; v1 = 0; vD = 0; cnd = 0; alu = 0;
        eAI = 0; eAV = 0; eM = 0; eJ = 0; eS = 0;
        fImm = 0; fMR = 0; fMW = 0; fNop = 0; fEnd = 0;
        imm = 0; jmp = 0; sO = 0; sD = 0; ill = 0;
        case (op)
            0: begin o1 = fld(ins,10,4); o2 = fld(ins,6,4); alu = 5; eAI = 1; end
            1: begin cnd = fld(ins,14,2); jmp = fld(ins,4,10); eJ = 1; end
            2, 6, 7: begin
                cnd = fld(ins,14,2); v1 = fld(ins,11,2); vD = fld(ins,9,2);
                o1 = fld(ins,5,4); alu = (op == 2) ? 0 : (op == 6) ? 1 : 2; eAV = 1;
            end
            3: begin
                cnd = fld(ins,14,2); v1 = fld(ins,11,2); vD = fld(ins,9,2);
                imm = fld(ins,4,5); fImm = 1; eAV = 1;
            end
            4, 5: begin
                cnd = fld(ins,14,2); o1 = fld(ins,10,4);
                if (op == 4) begin vD = fld(ins,8,2); fMR = 1; end
                else         begin v1 = fld(ins,8,2); fMW = 1; end
                imm = fld(ins,5,3); fImm = 1; eM = 1;
            end
            8: begin
                cnd = fld(ins,14,2); v1 = fld(ins,12,2); vD = fld(ins,10,2);
                sO = fld(ins,7,3); sD = fld(ins,4,3); eS = 1;
            end
            9, 10: begin
                o1 = fld(ins,12,4); d = fld(ins,8,4); o2 = fld(ins,4,4);
                cnd = 2; alu = (op == 9) ? 3 : 4; eAI = 1;
            end
            11, 12: begin
                o1 = fld(ins,12,4); d = fld(ins,8,4); imm = fld(ins,4,4); fImm = 1;
                cnd = 2; alu = (op == 11) ? 3 : 4; eAI = 1;
            end
            13: fNop = 1;
            14: fEnd = 1;
            default: begin ill = 1; fNop = 1; end
        endcase
        return {8'd0, 4'(o1), 4'(o2), 4'(d), 2'(v1), 2'(vD), 2'(cnd), 3'(alu),
                1'(eAI), 1'(eAV), 1'(eM), 1'(eJ), 1'(eS),
                1'(fImm), 1'(fMR), 1'(fMW), 1'(fNop), 1'(fEnd),
                8'(imm), 10'(jmp), 3'(sO), 3'(sD), 1'(ill)};
    endfunction

    // One clock: drive inputs, check in_ready, clock, update model, check outputs.
    task automatic step(input bit v, input logic [15:0] ins, input bit ordy,
                        input bit fl, input bit rn);
        bit expReady;
        in_valid = v; instruction = ins; out_ready = ordy; flush = fl; rst_n = rn;
        #1;
        expReady = !mHalted && (!mValid || ordy);
        check("in_ready", 64'(in_ready), 64'(expReady));
        @(posedge clk);
        if (!rn) begin
            mValid = 0; mHalted = 0; mIll = 0; mBundle = '0;
        end else if (fl) begin
            mValid = 0;
        end else if (v && expReady) begin
            mBundle = refDecode(ins);
            mValid = 1;
            if (ins[3:0] == 4'hF && mIll < 255) mIll++;
            if (ins[3:0] == 4'hE) mHalted = 1;
        end else if (ordy) begin
            mValid = 0;
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(mValid));
        check("halted", 64'(halted), 64'(mHalted));
        check("illCount", 64'(illCount), 64'(mIll));
        if (mValid) check("bundle", obsPack, mBundle);
    endtask

    task automatic checkResetState();
        check("rst_bundle", obsPack, 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_ill", 64'(illCount), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int haltAge;
        step(0, 16'h0000, 1, 0, 0);
        step(0, 16'h0000, 1, 0, 0);
        checkResetState();

        // ADD
        step(1, 16'h2139, 1, 0, 1);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_o1", 64'(intOper1), 64'd2);
        check("add_dst", 64'(intRegDest), 64'd1);
        check("add_o2", 64'(intOper2), 64'd3);
        check("add_alu", 64'(aluOpcode), 64'd3);
        check("add_cond", 64'(cond), 64'd2);
        check("add_en", 64'(enableAluInt), 64'd1);
        check("add_imm", 64'(ImmOut), 64'd0);
        check("add_jmp", 64'(jumpAddress), 64'd0);

        // VLD
        step(1, 16'h1664, 1, 0, 1);
        check("vld_o1", 64'(intOper1), 64'd5);
        check("vld_vdst", 64'(vRegDest), 64'd2);
        check("vld_imm", 64'(ImmOut), 64'd3);
        check("vld_flags", 64'({flagImm, flagMemRead, enableMem}), 64'b111);
        check("vld_cond", 64'(cond), 64'd0);

        // J held under backpressure, then drained
        step(1, 16'h9551, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 16'h2139, 0, 0, 1);
            check("hold_jmp", 64'(jumpAddress), 64'h155);
            check("hold_cond", 64'(cond), 64'd2);
            check("hold_en", 64'(enableJump), 64'd1);
            check("hold_ready", 64'(in_ready), 64'd0);
        end
        step(1, 16'h2139, 1, 0, 1);
        check("drain_o1", 64'(intOper1), 64'd2);

        // Flush in the middle of a stream
        step(1, 16'h1664, 1, 0, 1);
        step(1, 16'h9551, 1, 1, 1);
        check("flush_valid", 64'(out_valid), 64'd0);
        step(1, 16'h5A3A, 1, 0, 1);
        check("post_flush_alu", 64'(aluOpcode), 64'd4);
        check("post_flush_dst", 64'(intRegDest), 64'd10);
        step(0, 16'h0000, 1, 0, 1);

        // Illegal opcode saturation
        for (int i = 0; i < 300; i++) step(1, 16'h000F, 1, 0, 1);
        check("ill_flag", 64'({illegal, flagNop}), 64'b11);
        check("ill_sat", 64'(illCount), 64'd255);

        // END, halt survives flush, reset clears
        step(1, 16'h000E, 1, 0, 1);
        check("end_flag", 64'(flagEnd), 64'd1);
        check("end_halt", 64'(halted), 64'd1);
        step(1, 16'h2139, 1, 1, 1);
        check("halt_ready", 64'(in_ready), 64'd0);
        check("halt_keep", 64'(halted), 64'd1);
        check("halt_ill", 64'(illCount), 64'd255);
        step(1, 16'h2139, 1, 0, 1);
        check("halt_noacc", 64'(out_valid), 64'd0);
        step(0, 16'h0000, 1, 0, 0);
        checkResetState();

        // Random traffic
        haltAge = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] ins;
            int op;
            if (mHalted && haltAge > 4) begin
                step(0, 16'h0000, 1, 0, 0);
                haltAge = 0;
                continue;
            end
            if (mHalted) haltAge++;
            ins = 16'($urandom);
            op = int'(ins[3:0]);
            if (op == 14 && $urandom_range(0, 7) != 0) ins[3:0] = 4'($urandom_range(0, 12));
            step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
